obj_cmd_issuer: RTL
===================

# obj_cmd_issuer

Command-side front end for `object_unit`. It accepts one object command at a time from the CPU/matrix path over a valid/ready handshake, and pre-checks the command against `obj_map` and `obj_mem_full`. It then issues the single-cycle request pulse to `object_unit`, waits for that unit's completion signalling, and returns the object ID and a status over a valid/ready response channel. It enforces the rule that no new request is sent until the previous one completes.

## Interface
- `OBJ_W`, 5, object ID width (32 objects)
- `TIMEOUT`, 64, max cycles spent in WAIT_ADDR before giving up (≥4)

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `cmd_vld` in 1: command valid.
- `cmd_rdy` out 1: command ready. High only in IDLE.
- `cmd_op` in 2: command opcode. 00 CREATE, 01 DELETE, 10 REF, 11 DEL_ALL.
- `cmd_obj` in OBJ_W: target object ID. Ignored for CREATE and DEL_ALL.
- `rsp_vld` out 1: response valid.
- `rsp_rdy` in 1: response ready.
- `rsp_obj` out OBJ_W: returned object ID.
- `rsp_status` out 2: 00 OK, 01 FULL, 10 NOT_ALLOC, 11 TIMEOUT.
- `crt_obj`, `del_obj`, `del_all`, `ref_addr` out 1 each: request pulses to `object_unit`.
- `obj_num` out OBJ_W: object number sent to `object_unit`.
- `addr_vld` in 1: completion from `object_unit`.
- `addr` in OBJ_W: address from `object_unit`.
- `lst_stored_obj` in OBJ_W: ID allocated by `object_unit`.
- `lst_stored_obj_vld` in 1: `lst_stored_obj` valid.
- `obj_mem_full` in 1: `object_unit` full flag.
- `obj_map` in 32: allocation map from `object_unit`.

## Operation
- The state machine has five states: IDLE, ISSUE, WAIT_ADDR, SETTLE, RESP.
- **IDLE**
  - `cmd_rdy`=1.
  - On `cmd_vld`, latch `cmd_op` and `cmd_obj`, then run the pre-check:
    - CREATE with `obj_mem_full`=1 → RESP with FULL. `rsp_obj`=0.
    - DELETE or REF with `obj_map[cmd_obj]`=0 → RESP with NOT_ALLOC. `rsp_obj`=`cmd_obj`.
    - Otherwise → ISSUE. `obj_num` is loaded with `cmd_obj`.
- **ISSUE** lasts exactly one cycle. The pulse for the opcode is high; all other pulses are low. Next state:
  - CREATE and REF → WAIT_ADDR. The timer is cleared on entry.
  - DELETE → SETTLE.
  - DEL_ALL → RESP with OK and `rsp_obj`=0.
- **WAIT_ADDR**
  - When `lst_stored_obj_vld`=1, capture `lst_stored_obj` into the ID register. This applies to CREATE only.
  - When `addr_vld`=1 → RESP with OK.
    - CREATE returns the captured ID. If `lst_stored_obj_vld` and `addr_vld` arrive in the same cycle, `lst_stored_obj` is used directly.
    - REF returns `addr`.
  - If the timer reaches TIMEOUT-1 without `addr_vld` → RESP with TIMEOUT and `rsp_obj`=latched `cmd_obj`.
- **SETTLE** lasts one cycle, which lets `object_unit` commit the `obj_map` clear. Next state is RESP with OK and `rsp_obj`=`cmd_obj`.
- **RESP**
  - `rsp_vld`=1. `rsp_obj` and `rsp_status` are held stable.
  - On `rsp_rdy` → IDLE.
- Inputs outside their expected state are ignored:
  - `addr_vld` and `lst_stored_obj_vld` outside WAIT_ADDR.
  - `cmd_vld` outside IDLE.
- Reset, including reset mid-operation, returns the block to IDLE.
  - Outputs after reset: all pulses 0, `rsp_vld`=0, `rsp_obj`=0, `rsp_status`=00, `obj_num`=0, `cmd_rdy`=1, timer=0.
  - Any in-flight response is discarded.

## Timing
- Command accepted at edge k.
- Pre-check rejection: `rsp_vld` is high from cycle k+1.
- The request pulse is high for the single cycle k+1. Pulses are registered outputs.
- REF with no stalls: `addr_vld` arrives in cycle k+2 and `rsp_vld` is high in cycle k+3.
- DELETE: `rsp_vld` is high in cycle k+3.
- DEL_ALL: `rsp_vld` is high in cycle k+2.
- CREATE takes up to about 34 cycles, because `object_unit` scans the map for the next free slot.
- The next command is accepted at the earliest on the cycle after the `rsp_vld`&&`rsp_rdy` edge.
- At most one request is outstanding toward `object_unit` at any time.

## Structure
- Shared package `obj_pkg` holds:
  - The `OBJ_W` default and `NUM_OBJ`=32.
  - The `cmd_op` enum: CREATE, DELETE, REF, DEL_ALL.
  - The `rsp_status` enum: OK, FULL, NOT_ALLOC, TIMEOUT.
  - The state enum.
- One sub-module, `obj_wait_timer`:
  - A clearable up-counter sized $clog2(TIMEOUT).
  - Has a `clr` input and an `expired` output.

## Test plan
- Reset, then CREATE against a model returning `lst_stored_obj`=0 at k+2 and `addr_vld` at k+4 → exactly one `crt_obj` pulse at k+1; response OK, `rsp_obj`=0.
- Same CREATE with `obj_mem_full`=1 → no pulse; response FULL at k+1.
- DELETE with `cmd_obj`=7 and `obj_map[7]`=0 → NOT_ALLOC with `rsp_obj`=7, no `del_obj` pulse. Repeat with bit 7 set → `del_obj` pulse at k+1, `obj_num`=7, OK at k+3.
- REF with `cmd_obj`=12 and `addr_vld` never asserted → TIMEOUT with `rsp_obj`=12, after TIMEOUT cycles in WAIT_ADDR.
- DEL_ALL → `del_all` high for one cycle only; OK with `rsp_obj`=0 at k+2. Hold `rsp_rdy`=0 for 5 cycles → response stays stable, `cmd_rdy`=0, and a new `cmd_vld` is ignored.
- Assert `rst` while in WAIT_ADDR → all outputs return to their reset values immediately, with no pulse or response afterwards.

Source files
------------

// File: rtl/obj_pkg.sv
`default_nettype none
// ============================================================================
// Package     : obj_pkg
// Description : Shared types and constants for the object command issuer.
//               Holds the default object ID width, the object count, the
//               command opcode and response status encodings, and the
//               issuer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package obj_pkg;

  localparam int OBJ_W_DEF = 5;
  localparam int NUM_OBJ   = 32;

  typedef enum logic [1:0] {
    OP_CREATE  = 2'b00,
    OP_DELETE  = 2'b01,
    OP_REF     = 2'b10,
    OP_DEL_ALL = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_FULL      = 2'b01,
    ST_NOT_ALLOC = 2'b10,
    ST_TIMEOUT   = 2'b11
  } rsp_status_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_ADDR = 3'd2,
    S_SETTLE    = 3'd3,
    S_RESP      = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/obj_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : obj_wait_timer
// Description : Clearable up-counter bounding the time spent waiting for
//               object_unit completion. expired_o is high while the count
//               equals TIMEOUT-1.
// Ports       : clk, rst      - clock, async active-high reset
//               clr_i         - synchronous clear (dominates en_i)
//               en_i          - count enable
//               expired_o     - count has reached TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module obj_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/obj_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : obj_cmd_issuer
// Description : Command front end for object_unit. Accepts one command at a
//               time, pre-checks it against obj_map/obj_mem_full, issues a
//               single-cycle registered request pulse, waits for completion
//               and returns {object ID, status} on a valid/ready channel.
//               Only one request is ever outstanding toward object_unit.
// Ports       : clk, rst                    - clock, async active-high reset
//               cmd_vld_i/cmd_rdy_o         - command handshake
//               cmd_op_i, cmd_obj_i         - opcode and target object ID
//               rsp_vld_o/rsp_rdy_i         - response handshake
//               rsp_obj_o, rsp_status_o     - returned ID and status
//               crt_obj_o, del_obj_o,
//               del_all_o, ref_addr_o       - request pulses to object_unit
//               obj_num_o                   - object number to object_unit
//               addr_vld_i, addr_i          - completion and address
//               lst_stored_obj_i/_vld_i     - ID allocated on CREATE
//               obj_mem_full_i, obj_map_i   - object_unit status
// Revision    : 1.0 - initial release
// ============================================================================
module obj_cmd_issuer
  import obj_pkg::*;
#(
  parameter int OBJ_W   = OBJ_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_vld_i,
  output logic               cmd_rdy_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [OBJ_W-1:0]   cmd_obj_i,
  output logic               rsp_vld_o,
  input  logic               rsp_rdy_i,
  output logic [OBJ_W-1:0]   rsp_obj_o,
  output logic [1:0]         rsp_status_o,
  output logic               crt_obj_o,
  output logic               del_obj_o,
  output logic               del_all_o,
  output logic               ref_addr_o,
  output logic [OBJ_W-1:0]   obj_num_o,
  input  logic               addr_vld_i,
  input  logic [OBJ_W-1:0]   addr_i,
  input  logic [OBJ_W-1:0]   lst_stored_obj_i,
  input  logic               lst_stored_obj_vld_i,
  input  logic               obj_mem_full_i,
  input  logic [NUM_OBJ-1:0] obj_map_i
);

  state_e            state_q, state_d;
  cmd_op_e           op_q, op_d;
  logic [OBJ_W-1:0]  obj_q, obj_d;          // latched cmd_obj
  logic [OBJ_W-1:0]  rsp_obj_q, rsp_obj_d;  // response ID / CREATE capture
  rsp_status_e       status_q, status_d;
  logic [OBJ_W-1:0]  obj_num_q, obj_num_d;
  logic              crt_q, crt_d;
  logic              del_q, del_d;
  logic              dal_q, dal_d;
  logic              ref_q, ref_d;
  logic              tmr_expired;
  cmd_op_e           w_op;

  assign w_op = cmd_op_e'(cmd_op_i);

  // Timer is held at zero outside WAIT_ADDR, so it starts from 0 on entry.
  obj_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q != S_WAIT_ADDR),
    .en_i      (1'b1),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    obj_d     = obj_q;
    rsp_obj_d = rsp_obj_q;
    status_d  = status_q;
    obj_num_d = obj_num_q;
    crt_d     = 1'b0;
    del_d     = 1'b0;
    dal_d     = 1'b0;
    ref_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_vld_i) begin
          op_d  = w_op;
          obj_d = cmd_obj_i;
          if (w_op == OP_CREATE && obj_mem_full_i) begin
            state_d   = S_RESP;
            status_d  = ST_FULL;
            rsp_obj_d = '0;
          end else if ((w_op == OP_DELETE || w_op == OP_REF) &&
                       !obj_map_i[cmd_obj_i]) begin
            state_d   = S_RESP;
            status_d  = ST_NOT_ALLOC;
            rsp_obj_d = cmd_obj_i;
          end else begin
            state_d   = S_ISSUE;
            status_d  = ST_OK;
            obj_num_d = cmd_obj_i;
            // CREATE/DEL_ALL report 0 unless a CREATE capture overrides it.
            rsp_obj_d = (w_op == OP_CREATE || w_op == OP_DEL_ALL) ? '0 : cmd_obj_i;
            // Pulses are registered, so they are high exactly in ISSUE.
            crt_d = (w_op == OP_CREATE);
            del_d = (w_op == OP_DELETE);
            dal_d = (w_op == OP_DEL_ALL);
            ref_d = (w_op == OP_REF);
          end
        end
      end

      S_ISSUE: begin
        case (op_q)
          OP_CREATE,
          OP_REF:    state_d = S_WAIT_ADDR;
          OP_DELETE: state_d = S_SETTLE;
          default:   state_d = S_RESP;
        endcase
      end

      S_WAIT_ADDR: begin
        // Capturing into rsp_obj_d here also covers the case where the ID
        // and completion arrive together: the new ID flows straight out.
        if (lst_stored_obj_vld_i && op_q == OP_CREATE) begin
          rsp_obj_d = lst_stored_obj_i;
        end
        if (addr_vld_i) begin
          state_d  = S_RESP;
          status_d = ST_OK;
          if (op_q == OP_REF) begin
            rsp_obj_d = addr_i;
          end
        end else if (tmr_expired) begin
          state_d   = S_RESP;
          status_d  = ST_TIMEOUT;
          rsp_obj_d = obj_q;
        end
      end

      S_SETTLE: begin
        state_d   = S_RESP;
        rsp_obj_d = obj_q;
      end

      S_RESP: begin
        if (rsp_rdy_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_CREATE;
      obj_q     <= '0;
      rsp_obj_q <= '0;
      status_q  <= ST_OK;
      obj_num_q <= '0;
      crt_q     <= 1'b0;
      del_q     <= 1'b0;
      dal_q     <= 1'b0;
      ref_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      obj_q     <= obj_d;
      rsp_obj_q <= rsp_obj_d;
      status_q  <= status_d;
      obj_num_q <= obj_num_d;
      crt_q     <= crt_d;
      del_q     <= del_d;
      dal_q     <= dal_d;
      ref_q     <= ref_d;
    end
  end

  assign cmd_rdy_o    = (state_q == S_IDLE);
  assign rsp_vld_o    = (state_q == S_RESP);
  assign rsp_obj_o    = rsp_obj_q;
  assign rsp_status_o = status_q;
  assign obj_num_o    = obj_num_q;
  assign crt_obj_o    = crt_q;
  assign del_obj_o    = del_q;
  assign del_all_o    = dal_q;
  assign ref_addr_o   = ref_q;

endmodule
`default_nettype wire
